collect_money: RTL

- Payment-collection FSM; the input side of the vending datapath.
- Accepts 2-euro coin and 10-euro note insertion pulses and accumulates credit against a latched price.
- On payment or cancel/timeout, presents the change (or refund) amount to the change dispenser via a valid/ack handshake.
- Dispenser output feeds back here as changeAck once change has been fully paid out.

---
 rtl/collect_money.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/collect_money.sv
// Payment-collection controller: accumulates 2-euro coin and 10-euro note
// credit against a latched price, then hands change or a refund to the
// dispenser over a valid/ack handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a start with a legal price
// COLLECT | accepting insertions until credit covers the price
// DONE    | sale complete, change presented until changeAck
// REFUND  | cancelled or timed out, credit presented until changeAck
module collect_money #(
    parameter int MAX_CREDIT     = 30,
    parameter int MAX_PRICE      = 28,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] valueToPay,
    input  logic       coin2In,
    input  logic       note10In,
    input  logic       cancel,
    input  logic       changeAck,
    output logic [4:0] inputMoney,
    output logic       busy,
    output logic       coinReject,
    output logic       noteReject,
    output logic       priceError,
    output logic       changeValid,
    output logic [4:0] changeDue,
    output logic       paid,
    output logic       refund
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        REFUND  = 2'd3
    } state_t;

    localparam logic [5:0]  MAX_CREDIT_W = 6'(MAX_CREDIT);
    localparam logic [4:0]  MAX_PRICE_W  = 5'(MAX_PRICE);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  credit_q, credit_d;
    logic [4:0]  price_q, price_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  due_q, due_d;
    logic        cv_q, cv_d;
    logic        paid_q, paid_d;
    logic        refund_q, refund_d;
    logic        busy_q, busy_d;
    logic        coin_rej_q, coin_rej_d;
    logic        note_rej_q, note_rej_d;
    logic        price_err_q, price_err_d;

    logic        price_ok;
    logic        coin_ok;
    logic        note_ok;

    // Legal price: even, nonzero, within range. Coin is judged first; the
    // note sees the credit including an accepted coin (6-bit sums, no wrap).
    assign price_ok = (valueToPay[0] == 1'b0) && (valueToPay != 5'd0)
                      && (valueToPay <= MAX_PRICE_W);
    assign coin_ok  = coin2In && (({1'b0, credit_q} + 6'd2) <= MAX_CREDIT_W);
    assign note_ok  = note10In
                      && (({1'b0, credit_q} + (coin_ok ? 6'd2 : 6'd0) + 6'd10)
                          <= MAX_CREDIT_W);

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        price_d     = price_q;
        cnt_d       = cnt_q;
        due_d       = due_q;
        cv_d        = cv_q;
        paid_d      = paid_q;
        refund_d    = refund_q;
        coin_rej_d  = 1'b0;
        note_rej_d  = 1'b0;
        price_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                coin_rej_d = coin2In;
                note_rej_d = note10In;
                if (start) begin
                    if (price_ok) begin
                        price_d  = valueToPay;
                        credit_d = 5'd0;
                        cnt_d    = 16'd0;
                        state_d  = COLLECT;
                    end else begin
                        price_err_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (credit_q >= price_q) begin
                    state_d    = DONE;
                    due_d      = credit_q - price_q;
                    paid_d     = 1'b1;
                    cv_d       = 1'b1;
                    coin_rej_d = coin2In;
                    note_rej_d = note10In;
                end else if (cancel || (cnt_q == TIMEOUT_LAST)) begin
                    state_d    = REFUND;
                    due_d      = credit_q;
                    refund_d   = 1'b1;
                    cv_d       = 1'b1;
                    coin_rej_d = coin2In;
                    note_rej_d = note10In;
                end else begin
                    credit_d   = credit_q + (coin_ok ? 5'd2 : 5'd0)
                                          + (note_ok ? 5'd10 : 5'd0);
                    coin_rej_d = coin2In && !coin_ok;
                    note_rej_d = note10In && !note_ok;
                    cnt_d      = (coin_ok || note_ok) ? 16'd0 : cnt_q + 16'd1;
                end
            end
            DONE, REFUND: begin
                coin_rej_d = coin2In;
                note_rej_d = note10In;
                if (changeAck) begin
                    state_d  = IDLE;
                    credit_d = 5'd0;
                    due_d    = 5'd0;
                    cv_d     = 1'b0;
                    paid_d   = 1'b0;
                    refund_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset discards any credit in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            credit_q    <= 5'd0;
            price_q     <= 5'd0;
            cnt_q       <= 16'd0;
            due_q       <= 5'd0;
            cv_q        <= 1'b0;
            paid_q      <= 1'b0;
            refund_q    <= 1'b0;
            busy_q      <= 1'b0;
            coin_rej_q  <= 1'b0;
            note_rej_q  <= 1'b0;
            price_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            price_q     <= price_d;
            cnt_q       <= cnt_d;
            due_q       <= due_d;
            cv_q        <= cv_d;
            paid_q      <= paid_d;
            refund_q    <= refund_d;
            busy_q      <= busy_d;
            coin_rej_q  <= coin_rej_d;
            note_rej_q  <= note_rej_d;
            price_err_q <= price_err_d;
        end
    end

    assign inputMoney  = credit_q;
    assign busy        = busy_q;
    assign coinReject  = coin_rej_q;
    assign noteReject  = note_rej_q;
    assign priceError  = price_err_q;
    assign changeValid = cv_q;
    assign changeDue   = due_q;
    assign paid        = paid_q;
    assign refund      = refund_q;

endmodule
